mux_scan_sequencer: RTL and testbench

Round-robin channel scanner that sits directly around the 8:1 N-bit data multiplexer. It drives the multiplexer's 3-bit select, waits a fixed dwell time per channel, and registers the returned multiplexer output together with its channel index and a one-cycle valid strobe. It supports masked channels, single-sweep and continuous modes, and an abort.

---
 rtl/mux_pkg.sv | 27 ++
 rtl/mux_scan_sequencer_next_channel_finder.sv | 28 ++
 rtl/mux_scan_sequencer.sv | 164 ++++++++++++++++
 tb/tb_mux_scan_sequencer.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mux_pkg.sv
// mux_pkg: definitions shared by every sequencer that drives the 8:1 data
// multiplexer.
//   N_CHANNELS  - number of multiplexer inputs
//   SEL_W       - width of the multiplexer select
//   scan_state_t - sequencer state encoding (IDLE, SCAN)
//   lowest_set() - index of the lowest set bit of a channel mask (0 if none)
package mux_pkg;

  localparam int N_CHANNELS = 8;
  localparam int SEL_W      = 3;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } scan_state_t;

  // Walk from the top down so the last hit is the lowest set bit.
  function automatic logic [SEL_W-1:0] lowest_set(input logic [N_CHANNELS-1:0] m);
    logic [SEL_W-1:0] r;
    r = '0;
    for (int i = N_CHANNELS - 1; i >= 0; i--) begin
      if (m[i]) r = SEL_W'(i);
    end
    return r;
  endfunction

endpackage

// File: rtl/mux_scan_sequencer_next_channel_finder.sv
// next_channel_finder: combinational search over the latched channel mask.
//   mask_r     in   8  latched channel enables
//   cur_sel    in   3  channel currently on the multiplexer select
//   next_ch    out  3  lowest enabled channel strictly above cur_sel
//   lowest_ch  out  3  lowest enabled channel overall (start of a sweep)
//   wrap       out  1  no enabled channel above cur_sel: the sweep ends here
module next_channel_finder
  import mux_pkg::*;
(
  input  logic [N_CHANNELS-1:0] mask_r,
  input  logic [SEL_W-1:0]      cur_sel,
  output logic [SEL_W-1:0]      next_ch,
  output logic [SEL_W-1:0]      lowest_ch,
  output logic                  wrap
);

  // Enabled channels that lie above the current one.
  logic [N_CHANNELS-1:0] above;

  for (genvar gi = 0; gi < N_CHANNELS; gi++) begin : g_above
    assign above[gi] = mask_r[gi] && (SEL_W'(gi) > cur_sel);
  end

  assign next_ch   = lowest_set(above);
  assign lowest_ch = lowest_set(mask_r);
  assign wrap      = (above == '0);

endmodule

// File: rtl/mux_scan_sequencer.sv
// mux_scan_sequencer: round-robin scanner wrapped around an 8:1 multiplexer.
// Each enabled channel is held on sel for DWELL cycles, then the multiplexer
// output is captured together with its channel index and a one-cycle strobe.
//   clock        in   1     rising-edge clock
//   reset_n      in   1     asynchronous active-low reset
//   start        in   1     begin a scan (honoured only in IDLE, mask != 0)
//   stop         in   1     abort the scan at the next edge
//   continuous   in   1     latched with start: 1 = loop sweeps, 0 = one sweep
//   mask         in   8     channel enables, latched with start
//   mux_in       in   BITS  multiplexer output for the current sel
//   sel          out  3     multiplexer select (registered)
//   data_out     out  BITS  last captured sample
//   data_ch      out  3     channel of data_out
//   data_valid   out  1     one-cycle strobe for a new sample
//   busy         out  1     scanning
//   done         out  1     one-cycle strobe at the end of a single sweep
//   sweep_count  out  8     completed sweeps since the last accepted start
module mux_scan_sequencer
  import mux_pkg::*;
#(
  parameter int BITS  = 4,
  parameter int DWELL = 4
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  continuous,
  input  logic [N_CHANNELS-1:0] mask,
  input  logic [BITS-1:0]       mux_in,
  output logic [SEL_W-1:0]      sel,
  output logic [BITS-1:0]       data_out,
  output logic [SEL_W-1:0]      data_ch,
  output logic                  data_valid,
  output logic                  busy,
  output logic                  done,
  output logic [7:0]            sweep_count
);

  localparam int CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL - 1);

  scan_state_t           state_reg, state_next;
  logic [CNT_W-1:0]      cnt_reg, cnt_next;
  logic [SEL_W-1:0]      sel_reg, sel_next;
  logic [N_CHANNELS-1:0] mask_r, mask_next;
  logic                  cont_r, cont_next;
  logic [BITS-1:0]       data_out_reg, data_out_next;
  logic [SEL_W-1:0]      data_ch_reg, data_ch_next;
  logic                  data_valid_reg, data_valid_next;
  logic                  busy_reg, busy_next;
  logic                  done_reg, done_next;
  logic [7:0]            sweep_reg, sweep_next;

  logic [SEL_W-1:0]      next_ch;
  logic [SEL_W-1:0]      lowest_ch;
  logic                  wrap;

  next_channel_finder u_finder (
    .mask_r    (mask_r),
    .cur_sel   (sel_reg),
    .next_ch   (next_ch),
    .lowest_ch (lowest_ch),
    .wrap      (wrap)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_reg      <= IDLE;
      cnt_reg        <= '0;
      sel_reg        <= '0;
      mask_r         <= '0;
      cont_r         <= 1'b0;
      data_out_reg   <= '0;
      data_ch_reg    <= '0;
      data_valid_reg <= 1'b0;
      busy_reg       <= 1'b0;
      done_reg       <= 1'b0;
      sweep_reg      <= '0;
    end else begin
      state_reg      <= state_next;
      cnt_reg        <= cnt_next;
      sel_reg        <= sel_next;
      mask_r         <= mask_next;
      cont_r         <= cont_next;
      data_out_reg   <= data_out_next;
      data_ch_reg    <= data_ch_next;
      data_valid_reg <= data_valid_next;
      busy_reg       <= busy_next;
      done_reg       <= done_next;
      sweep_reg      <= sweep_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    cnt_next        = cnt_reg;
    sel_next        = sel_reg;
    mask_next       = mask_r;
    cont_next       = cont_r;
    data_out_next   = data_out_reg;
    data_ch_next    = data_ch_reg;
    data_valid_next = 1'b0;
    busy_next       = busy_reg;
    done_next       = 1'b0;
    sweep_next      = sweep_reg;

    unique case (state_reg)
      IDLE: begin
        // The incoming mask is not latched yet, so its lowest channel is
        // taken directly rather than from the finder.
        if (start && !stop && (mask != '0)) begin
          state_next = SCAN;
          mask_next  = mask;
          cont_next  = continuous;
          sel_next   = lowest_set(mask);
          cnt_next   = '0;
          sweep_next = '0;
          busy_next  = 1'b1;
        end
      end

      SCAN: begin
        if (stop) begin
          state_next = IDLE;
          busy_next  = 1'b0;
          sel_next   = '0;
          cnt_next   = '0;
        end else if (cnt_reg == CNT_LAST) begin
          cnt_next        = '0;
          data_out_next   = mux_in;
          data_ch_next    = sel_reg;
          data_valid_next = 1'b1;
          if (!wrap) begin
            sel_next = next_ch;
          end else begin
            sweep_next = sweep_reg + 8'd1;
            if (cont_r) begin
              sel_next = lowest_ch;
            end else begin
              state_next = IDLE;
              busy_next  = 1'b0;
              done_next  = 1'b1;
              sel_next   = '0;
            end
          end
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end

      default: state_next = IDLE;
    endcase
  end

  assign sel         = sel_reg;
  assign data_out    = data_out_reg;
  assign data_ch     = data_ch_reg;
  assign data_valid  = data_valid_reg;
  assign busy        = busy_reg;
  assign done        = done_reg;
  assign sweep_count = sweep_reg;

endmodule

// File: tb/tb_mux_scan_sequencer.sv
// Testbench for mux_scan_sequencer: a DWELL=4 instance checked every cycle
// against a time-based reference model, plus a DWELL=1 instance for the
// single-channel continuous case.
module tb_mux_scan_sequencer;

  localparam int BITS  = 4;
  localparam int DWELL = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  always #5 clk = ~clk;

  // DWELL=4 instance
  logic       start, stop, continuous;
  logic [7:0] mask;
  logic [3:0] mux_in;
  logic [2:0] sel, data_ch;
  logic [3:0] data_out;
  logic       data_valid, busy, done;
  logic [7:0] sweep_count;

  // DWELL=1 instance
  logic       start1, stop1, continuous1;
  logic [7:0] mask1;
  logic [3:0] mux_in1;
  logic [2:0] sel1, data_ch1;
  logic [3:0] data_out1;
  logic       data_valid1, busy1, done1;
  logic [7:0] sweep_count1;

  // Multiplexer model: input i carries value i+1.
  assign mux_in  = 4'(sel)  + 4'd1;
  assign mux_in1 = 4'(sel1) + 4'd1;

  mux_scan_sequencer #(.BITS(BITS), .DWELL(DWELL)) u_dut (
    .clock(clk), .reset_n(rst_n), .start(start), .stop(stop),
    .continuous(continuous), .mask(mask), .mux_in(mux_in), .sel(sel),
    .data_out(data_out), .data_ch(data_ch), .data_valid(data_valid),
    .busy(busy), .done(done), .sweep_count(sweep_count)
  );

  mux_scan_sequencer #(.BITS(BITS), .DWELL(1)) u_dut1 (
    .clock(clk), .reset_n(rst_n), .start(start1), .stop(stop1),
    .continuous(continuous1), .mask(mask1), .mux_in(mux_in1), .sel(sel1),
    .data_out(data_out1), .data_ch(data_ch1), .data_valid(data_valid1),
    .busy(busy1), .done(done1), .sweep_count(sweep_count1)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // A scan is described by its ordered channel list and the number of
  // cycles elapsed since the accepted start; everything else is arithmetic.
  int  m_list[$];
  bit  m_active = 0;
  bit  m_cont   = 0;
  int  m_t      = 0;
  int  e_sel = 0, e_dout = 0, e_dch = 0, e_valid = 0, e_done = 0, e_sweep = 0;

  task automatic model_reset();
    m_active = 0; m_t = 0;
    e_sel = 0; e_dout = 0; e_dch = 0; e_valid = 0; e_done = 0; e_sweep = 0;
  endtask

  task automatic model_step();
    int m, slot, ch;
    if (!rst_n) begin
      model_reset();
      return;
    end
    e_valid = 0;
    e_done  = 0;
    if (!m_active) begin
      if (start && !stop && mask != 8'h00) begin
        m_list.delete();
        for (int i = 0; i < 8; i++) if (mask[i]) m_list.push_back(i);
        m_active = 1;
        m_cont   = continuous;
        m_t      = 0;
        e_sweep  = 0;
        e_sel    = m_list[0];
      end
    end else if (stop) begin
      m_active = 0;
      e_sel    = 0;
    end else begin
      m = m_list.size();
      m_t++;
      if (m_t % DWELL == 0) begin
        slot    = m_t / DWELL - 1;
        ch      = m_list[slot % m];
        e_dout  = ch + 1;
        e_dch   = ch;
        e_valid = 1;
        if (slot % m == m - 1) begin
          e_sweep = (e_sweep + 1) % 256;
          if (!m_cont) begin
            m_active = 0;
            e_done   = 1;
            e_sel    = 0;
          end
        end
      end
      if (m_active) e_sel = m_list[(m_t / DWELL) % m];
    end
  endtask

  // One clock: model advances on the edge, DUT compared on the falling edge.
  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    chk("sel",         int'(sel),         e_sel);
    chk("data_valid",  int'(data_valid),  e_valid);
    chk("data_out",    int'(data_out),    e_dout);
    chk("data_ch",     int'(data_ch),     e_dch);
    chk("busy",        int'(busy),        int'(m_active));
    chk("done",        int'(done),        e_done);
    chk("sweep_count", int'(sweep_count), e_sweep);
    if (data_valid)
      $display("sample ch=%0d data=%0d sweep=%0d done=%0d t=%0t",
               data_ch, data_out, sweep_count, done, $time);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, ".sel"},         int'(sel),         0);
    chk({tag, ".data_out"},    int'(data_out),    0);
    chk({tag, ".data_ch"},     int'(data_ch),     0);
    chk({tag, ".data_valid"},  int'(data_valid),  0);
    chk({tag, ".busy"},        int'(busy),        0);
    chk({tag, ".done"},        int'(done),        0);
    chk({tag, ".sweep_count"}, int'(sweep_count), 0);
  endtask

  // ---------------- single-sweep vector table ----------------
  typedef struct {
    logic [7:0] mask;
    int         n;        // expected number of samples
    int         chs[8];   // expected channel order
  } vec_t;

  vec_t vecs[5];

  initial begin
    int nval, busy_cyc, done_at, valid_at[$];

    vecs[0] = '{mask: 8'hFF,        n: 8, chs: '{0, 1, 2, 3, 4, 5, 6, 7}};
    vecs[1] = '{mask: 8'b1010_0100, n: 3, chs: '{2, 5, 7, 0, 0, 0, 0, 0}};
    vecs[2] = '{mask: 8'h00,        n: 0, chs: '{0, 0, 0, 0, 0, 0, 0, 0}};
    vecs[3] = '{mask: 8'h01,        n: 1, chs: '{0, 0, 0, 0, 0, 0, 0, 0}};
    vecs[4] = '{mask: 8'h80,        n: 1, chs: '{7, 0, 0, 0, 0, 0, 0, 0}};

    rst_n = 1'b0;
    start = 0; stop = 0; continuous = 0; mask = 8'h00;
    start1 = 0; stop1 = 0; continuous1 = 0; mask1 = 8'h00;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_reset_outputs("reset");
    rst_n = 1'b1;
    tick();

    // Table of single sweeps: sample order, busy length, done position.
    for (int v = 0; v < 5; v++) begin
      mask = vecs[v].mask; continuous = 0; start = 1;
      tick();
      start = 0; mask = 8'h00;
      nval = 0; busy_cyc = busy ? 1 : 0; done_at = -1;
      valid_at.delete();
      for (int c = 1; c <= 8 * DWELL + 4; c++) begin
        tick();
        if (busy) busy_cyc++;
        if (done) done_at = c;
        if (data_valid) begin
          valid_at.push_back(c);
          if (nval < 8) begin
            chk($sformatf("vec%0d.ch%0d", v, nval), int'(data_ch), vecs[v].chs[nval]);
            chk($sformatf("vec%0d.data%0d", v, nval), int'(data_out), vecs[v].chs[nval] + 1);
          end
          nval++;
        end
      end
      chk($sformatf("vec%0d.samples", v), nval, vecs[v].n);
      chk($sformatf("vec%0d.busy_cycles", v), busy_cyc, vecs[v].n * DWELL);
      chk($sformatf("vec%0d.done_at", v), done_at, (vecs[v].n > 0) ? vecs[v].n * DWELL : -1);
      for (int k = 0; k < valid_at.size(); k++)
        chk($sformatf("vec%0d.valid_at%0d", v, k), valid_at[k], (k + 1) * DWELL);
      chk($sformatf("vec%0d.sweeps", v), int'(sweep_count), 1);
      $display("vector %0d mask=%02h samples=%0d busy=%0d done_at=%0d",
               v, vecs[v].mask, nval, busy_cyc, done_at);
    end

    // Continuous 0,7 alternation, then stop in the second cycle of a dwell.
    mask = 8'h81; continuous = 1; start = 1;
    tick();
    start = 0;
    nval = 0;
    for (int c = 0; c < 40 && nval < 3; c++) begin
      tick();
      if (data_valid) begin
        chk($sformatf("cont.ch%0d", nval), int'(data_ch), (nval % 2) ? 7 : 0);
        chk($sformatf("cont.sweep%0d", nval), int'(sweep_count), (nval + 1) / 2);
        nval++;
      end
    end
    chk("cont.samples_before_stop", nval, 3);
    tick();                     // second cycle of the channel-7 dwell
    stop = 1;
    tick();
    stop = 0;
    chk("stop.busy", int'(busy), 0);
    chk("stop.sel", int'(sel), 0);
    nval = 0; done_at = 0;
    repeat (12) begin
      tick();
      if (data_valid) nval++;
      if (done) done_at++;
    end
    chk("stop.no_valid", nval, 0);
    chk("stop.no_done", done_at, 0);
    chk("stop.sweep_hold", int'(sweep_count), 1);
    $display("sequence continuous/stop complete");

    // start together with stop in IDLE is ignored.
    mask = 8'hFF; start = 1; stop = 1;
    tick();
    start = 0; stop = 0;
    chk("start_stop.busy", int'(busy), 0);
    nval = 0;
    repeat (6) begin tick(); if (data_valid || busy) nval++; end
    chk("start_stop.quiet", nval, 0);
    $display("sequence start+stop complete");

    // Second start and mask change mid-scan do not disturb the sweep.
    mask = 8'b1010_0100; continuous = 0; start = 1;
    tick();
    start = 0;
    repeat (5) tick();
    mask = 8'hFF; continuous = 1; start = 1;
    tick();
    start = 0; mask = 8'h0F;
    nval = 0; done_at = -1;
    for (int c = 7; c <= 20; c++) begin
      tick();
      if (data_valid) nval++;
      if (done) done_at = c;
    end
    chk("restart.samples_after", nval, 2);
    chk("restart.done_at", done_at, 12);
    chk("restart.busy_end", int'(busy), 0);
    $display("sequence mid-scan restart complete");

    // Mid-scan reset.
    mask = 8'hFF; continuous = 1; start = 1;
    tick();
    start = 0;
    repeat (6) tick();
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("midreset");
    model_reset();
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (5) tick();
    chk("post_reset.idle", int'(busy), 0);
    mask = 8'b1010_0100; continuous = 0; start = 1;
    tick();
    start = 0;
    done_at = -1;
    for (int c = 1; c <= 14; c++) begin
      tick();
      if (done) done_at = c;
    end
    chk("post_reset.done_at", done_at, 12);
    $display("sequence mid-scan reset complete");

    // DWELL=1, single channel 4, continuous.
    mask1 = 8'h10; continuous1 = 1; start1 = 1;
    tick();
    start1 = 0; mask1 = 8'h00;
    chk("d1.sel_start", int'(sel1), 4);
    chk("d1.valid_start", int'(data_valid1), 0);
    for (int j = 1; j <= 8; j++) begin
      tick();
      chk("d1.sel", int'(sel1), 4);
      chk("d1.valid", int'(data_valid1), 1);
      chk("d1.data", int'(data_out1), 5);
      chk("d1.ch", int'(data_ch1), 4);
      chk("d1.sweeps", int'(sweep_count1), j);
      chk("d1.busy", int'(busy1), 1);
    end
    stop1 = 1;
    tick();
    stop1 = 0;
    chk("d1.stop_busy", int'(busy1), 0);
    chk("d1.stop_valid", int'(data_valid1), 0);
    $display("sequence dwell-1 complete");

    // Randomized traffic against the model.
    for (int c = 0; c < 2000; c++) begin
      start      = ($urandom_range(0, 9) == 0);
      stop       = ($urandom_range(0, 39) == 0);
      continuous = $urandom_range(0, 1) == 1;
      mask       = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
      tick();
    end
    start = 0; stop = 0;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
